nf10_axi_lite_master: RTL and testbench
=======================================

// Module: nf10_axi_lite_master
// PURPOSE
//  Single-outstanding AXI4-Lite initiator. Turns a simple command/response stream into
//  S_AXI-style register reads/writes for nf10 peripherals (10G interface, NIC blocks).
//  Sits between the host/test command source and the AXI-Lite interconnect.
//  Provides a bounded response-wait timeout with a sticky error flag.
// PARAMETERS
//  C_M_AXI_ADDR_WIDTH   32     address width
//  C_M_AXI_DATA_WIDTH   32     data width; only 32 is supported
//  C_TIMEOUT_CYCLES     1024   response-wait limit in cycles (>=2); counter is clog2+1 bits
// PORTS
//  axi_aclk        in   1    sole clock
//  axi_reset       in   1    synchronous reset, active-high
//  cmd_valid       in   1    command present
//  cmd_ready       out  1    command accepted when valid&ready
//  cmd_wr          in   1    1=write, 0=read
//  cmd_addr        in   32   byte address; bits[1:0] forced to 0 on the bus
//  cmd_wdata       in   32   write data
//  cmd_wstrb       in   4    write byte strobes
//  rsp_valid       out  1    response present
//  rsp_ready       in   1    response consumed when valid&ready
//  rsp_rdata       out  32   read data (0 for writes)
//  rsp_resp        out  2    AXI BRESP/RRESP; 2'b10 on timeout
//  rsp_timeout     out  1    response produced by timeout
//  err_timeout     out  1    sticky; cleared only by reset
//  M_AXI_AWADDR/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY,
//  M_AXI_ARADDR/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY   standard AXI4-Lite master
// BEHAVIOUR
//  Reset: all outputs 0. cmd_ready rises on the first cycle after reset deasserts.
//  Outputs are registered. Address, data and strobe outputs hold their last value.
//  FSM: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP.
//  IDLE: cmd_ready=1. On cmd_valid: latch the command, drop cmd_ready, then go to WR_REQ or RD_REQ.
//  WR_REQ: AWVALID and WVALID assert together, on the cycle after accept.
//   - Each drops independently on the cycle after its own READY is sampled high.
//   - AW-before-W, W-before-AW and simultaneous completion must all work.
//   - When both are done: BREADY=1, go to WR_RESP.
//  WR_RESP: on BVALID: capture BRESP, BREADY=0, go to RESP.
//  RD_REQ: ARVALID=1 until ARREADY; then RREADY=1, go to RD_RESP.
//  RD_RESP: on RVALID: capture RDATA and RRESP, RREADY=0, go to RESP.
//  VALID handshakes: a VALID is never deasserted before its READY; a VALID never waits on READY.
//   - The request phases therefore have no timeout.
//  Timeout: the counter clears on entry to WR_RESP/RD_RESP and increments each waiting cycle.
//   - At C_TIMEOUT_CYCLES without B/RVALID: drop B/RREADY, rsp_resp=2'b10, rsp_rdata=0,
//     rsp_timeout=1, err_timeout<=1, go to RESP.
//   - A late B/R response is never accepted: BREADY/RREADY stay 0 outside the wait states.
//   - If VALID arrives on the expiry cycle, the real response wins (no timeout).
//  RESP: rsp_valid=1 until rsp_ready; then IDLE, cmd_ready=1 the next cycle.
//   - rsp_timeout=0 on normal completion.
//  Best-case latency, command accept to rsp_valid, with a zero-wait slave: 4 cycles.
//   - Back-to-back commands add one IDLE cycle.
//  Reset mid-transaction: everything returns to reset values immediately.
//   - The interconnect must be reset together with this block.
// STRUCTURE
//  Package nf10_axil_pkg: AXI resp localparams (OKAY=2'b00, SLVERR=2'b10),
//  FSM state encoding, cmd/rsp struct widths.
//  Single module; no sub-module. The timeout counter is inline.
// TESTING
//  1 Write 0x77a60004 <= 0xDEADBEEF, strb 0xF, AWREADY/WREADY same cycle
//    -> one AW and one W beat with addr 0x77a60004; rsp_resp=00; rsp_valid 4 cycles after accept.
//  2 Write with WREADY 3 cycles before AWREADY, then the reverse
//    -> each VALID held until its own READY; exactly one beat each; one response.
//  3 Read 0x77a60010, slave returns 0x12345678/OKAY after 5-cycle RVALID delay
//    -> rsp_rdata=0x12345678, rsp_resp=00, rsp_timeout=0.
//  4 Read where the slave never asserts RVALID, C_TIMEOUT_CYCLES=16
//    -> RREADY drops after 16 cycles; rsp_resp=10; rsp_timeout=1; err_timeout stays 1.
//  5 cmd_addr=0x77a60003, rsp_ready held low 10 cycles, then a second command queued
//    -> ARADDR=0x77a60000; rsp fields stable while stalled; second command accepted only after rsp handshake.
//  6 Assert axi_reset during WR_REQ with AWVALID high
//    -> all VALID/READY outputs 0 the next cycle; err_timeout=0; a new write completes normally.

Source files
------------

// File: rtl/nf10_axil_pkg.sv
// ============================================================================
// Module   : nf10_axil_pkg
// Brief    : Shared AXI4-Lite response codes, FSM encoding and field widths
//            for the nf10 AXI-Lite master.
// Revision : 1.0
// ============================================================================
`default_nettype none

package nf10_axil_pkg;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    localparam int c_CMD_ADDR_W = 32;
    localparam int c_CMD_DATA_W = 32;
    localparam int c_CMD_STRB_W = c_CMD_DATA_W / 8;
    localparam int c_RSP_RESP_W = 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_RESP = 3'd4,
        S_RESP    = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/nf10_axi_lite_master.sv
// ============================================================================
// Module   : nf10_axi_lite_master
// Brief    : Single-outstanding AXI4-Lite initiator with a bounded response
//            wait and a sticky timeout error flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nf10_axi_lite_master
    import nf10_axil_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = c_CMD_ADDR_W,
    parameter int C_M_AXI_DATA_WIDTH = c_CMD_DATA_W,
    parameter int C_TIMEOUT_CYCLES   = 1024
) (
    input  logic                            axi_aclk,
    input  logic                            axi_reset,

    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_wr,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [c_RSP_RESP_W-1:0]         rsp_resp,
    output logic                            rsp_timeout,
    output logic                            err_timeout,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int c_CNT_W = $clog2(C_TIMEOUT_CYCLES) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(C_TIMEOUT_CYCLES - 1);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] c_ADDR_MASK = ~C_M_AXI_ADDR_WIDTH'(3);

    state_t                            r_state;
    logic [c_CNT_W-1:0]                r_cnt;
    logic                              r_cmd_ready;
    logic                              r_rsp_valid;
    logic [C_M_AXI_DATA_WIDTH-1:0]     r_rsp_rdata;
    logic [1:0]                        r_rsp_resp;
    logic                              r_rsp_timeout;
    logic                              r_err_timeout;
    logic [C_M_AXI_ADDR_WIDTH-1:0]     r_awaddr;
    logic                              r_awvalid;
    logic [C_M_AXI_DATA_WIDTH-1:0]     r_wdata;
    logic [C_M_AXI_DATA_WIDTH/8-1:0]   r_wstrb;
    logic                              r_wvalid;
    logic                              r_bready;
    logic [C_M_AXI_ADDR_WIDTH-1:0]     r_araddr;
    logic                              r_arvalid;
    logic                              r_rready;

    // A channel counts as done once its VALID has dropped or its READY is seen now.
    logic w_aw_done;
    logic w_w_done;
    assign w_aw_done = !r_awvalid || M_AXI_AWREADY;
    assign w_w_done  = !r_wvalid  || M_AXI_WREADY;

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= c_RESP_OKAY;
            r_rsp_timeout <= 1'b0;
            r_err_timeout <= 1'b0;
            r_awaddr      <= '0;
            r_awvalid     <= 1'b0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_araddr      <= '0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_cmd_ready) begin
                        r_cmd_ready <= 1'b1;
                    end else if (cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        if (cmd_wr) begin
                            r_awaddr  <= cmd_addr & c_ADDR_MASK;
                            r_wdata   <= cmd_wdata;
                            r_wstrb   <= cmd_wstrb;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WR_REQ;
                        end else begin
                            r_araddr  <= cmd_addr & c_ADDR_MASK;
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_REQ;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (r_awvalid && M_AXI_AWREADY) r_awvalid <= 1'b0;
                    if (r_wvalid && M_AXI_WREADY)   r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    // A real response on the expiry cycle takes priority over the timeout.
                    if (M_AXI_BVALID) begin
                        r_bready      <= 1'b0;
                        r_rsp_resp    <= M_AXI_BRESP;
                        r_rsp_rdata   <= '0;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= S_RESP;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_bready      <= 1'b0;
                        r_rsp_resp    <= c_RESP_SLVERR;
                        r_rsp_rdata   <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_err_timeout <= 1'b1;
                        r_state       <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RD_REQ: begin
                    if (M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_RD_RESP;
                    end
                end
                S_RD_RESP: begin
                    if (M_AXI_RVALID) begin
                        r_rready      <= 1'b0;
                        r_rsp_resp    <= M_AXI_RRESP;
                        r_rsp_rdata   <= M_AXI_RDATA;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= S_RESP;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_rready      <= 1'b0;
                        r_rsp_resp    <= c_RESP_SLVERR;
                        r_rsp_rdata   <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_err_timeout <= 1'b1;
                        r_state       <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign rsp_timeout   = r_rsp_timeout;
    assign err_timeout   = r_err_timeout;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule

`default_nettype wire

// File: tb/tb_nf10_axi_lite_master.sv
// ============================================================================
// Module   : tb_nf10_axi_lite_master
// Brief    : Scoreboard bench for nf10_axi_lite_master against a small
//            configurable AXI4-Lite slave model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_nf10_axi_lite_master;

    localparam int c_TO = 16;

    logic        clk = 1'b0;
    logic        axi_reset;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout, err_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    nf10_axi_lite_master #(.C_TIMEOUT_CYCLES(c_TO)) dut (
        .axi_aclk(clk), .axi_reset(axi_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .err_timeout(err_timeout),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
    logic        r_never = 1'b0;
    logic [31:0] s_rdata = 32'h0;
    logic [1:0]  s_rresp = 2'b00, s_bresp = 2'b00;
    int          s_aw_cnt, s_w_cnt, s_ar_cnt, s_r_cnt;
    logic        s_aw_got, s_w_got, s_bvalid, s_r_pend, s_rvalid;
    logic        aw_hs, w_hs, ar_hs;

    assign awready = awvalid && (s_aw_cnt >= aw_dly);
    assign wready  = wvalid  && (s_w_cnt  >= w_dly);
    assign arready = arvalid && (s_ar_cnt >= ar_dly);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;
    assign bvalid  = s_bvalid;
    assign bresp   = s_bresp;
    assign rvalid  = s_rvalid;
    assign rdata   = s_rvalid ? s_rdata : 32'h0;
    assign rresp   = s_rresp;

    always @(posedge clk) begin
        if (axi_reset) begin
            s_aw_cnt <= 0; s_w_cnt <= 0; s_ar_cnt <= 0; s_r_cnt <= 0;
            s_aw_got <= 1'b0; s_w_got <= 1'b0; s_bvalid <= 1'b0;
            s_r_pend <= 1'b0; s_rvalid <= 1'b0;
        end else begin
            s_aw_cnt <= (awvalid && !awready) ? s_aw_cnt + 1 : 0;
            s_w_cnt  <= (wvalid && !wready)   ? s_w_cnt + 1  : 0;
            s_ar_cnt <= (arvalid && !arready) ? s_ar_cnt + 1 : 0;
            if (s_bvalid && bready) s_bvalid <= 1'b0;
            if ((s_aw_got || aw_hs) && (s_w_got || w_hs)) begin
                s_bvalid <= 1'b1;
                s_aw_got <= 1'b0;
                s_w_got  <= 1'b0;
            end else begin
                if (aw_hs) s_aw_got <= 1'b1;
                if (w_hs)  s_w_got  <= 1'b1;
            end
            if (ar_hs) begin
                s_r_pend <= 1'b1;
                s_r_cnt  <= 0;
            end else if (s_r_pend && !s_rvalid && !r_never) begin
                if (s_r_cnt >= r_dly) s_rvalid <= 1'b1;
                else                  s_r_cnt  <= s_r_cnt + 1;
            end
            if (s_rvalid && rready) begin
                s_rvalid <= 1'b0;
                s_r_pend <= 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
        logic        err;
    } rsp_t;

    logic [31:0] exp_aw[$];
    logic [35:0] exp_w[$];
    logic [31:0] exp_ar[$];
    rsp_t        exp_rsp[$];

    logic        prev_aw_wait, prev_w_wait, prev_ar_wait, prev_stall;
    logic [35:0] prev_snap;

    always @(negedge clk) begin : monitor
        rsp_t er;
        logic [35:0] eb;
        if (axi_reset) begin
            prev_aw_wait <= 1'b0;
            prev_w_wait  <= 1'b0;
            prev_ar_wait <= 1'b0;
            prev_stall   <= 1'b0;
        end else begin
            if (prev_aw_wait) chk("awvalid_hold", awvalid, 1);
            if (prev_w_wait)  chk("wvalid_hold", wvalid, 1);
            if (prev_ar_wait) chk("arvalid_hold", arvalid, 1);
            prev_aw_wait <= awvalid && !awready;
            prev_w_wait  <= wvalid && !wready;
            prev_ar_wait <= arvalid && !arready;

            if (aw_hs) begin
                if (exp_aw.size() == 0) chk("aw_extra_beat", 1, 0);
                else begin eb = {4'h0, exp_aw.pop_front()}; chk("aw_addr", awaddr, eb[31:0]); end
            end
            if (w_hs) begin
                if (exp_w.size() == 0) chk("w_extra_beat", 1, 0);
                else begin eb = exp_w.pop_front(); chk("w_data_strb", {wdata, wstrb}, eb); end
            end
            if (ar_hs) begin
                if (exp_ar.size() == 0) chk("ar_extra_beat", 1, 0);
                else begin eb = {4'h0, exp_ar.pop_front()}; chk("ar_addr", araddr, eb[31:0]); end
            end

            if (prev_stall) chk("rsp_stable", {rsp_valid, rsp_rdata, rsp_resp, rsp_timeout}, prev_snap);
            prev_stall <= rsp_valid && !rsp_ready;
            prev_snap  <= {rsp_valid, rsp_rdata, rsp_resp, rsp_timeout};

            if (rsp_valid && rsp_ready) begin
                if (exp_rsp.size() == 0) chk("rsp_extra", 1, 0);
                else begin
                    er = exp_rsp.pop_front();
                    chk("rsp_rdata", rsp_rdata, er.rdata);
                    chk("rsp_resp", rsp_resp, er.resp);
                    chk("rsp_timeout", rsp_timeout, er.to);
                    chk("err_timeout", err_timeout, er.err);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [31:0] e_rdata,
                            input logic [1:0] e_resp, input logic e_to, input logic e_err,
                            output int acc);
        rsp_t r;
        if (wr) begin
            exp_aw.push_back(addr & 32'hFFFF_FFFC);
            exp_w.push_back({data, strb});
        end else begin
            exp_ar.push_back(addr & 32'hFFFF_FFFC);
        end
        r.rdata = e_rdata; r.resp = e_resp; r.to = e_to; r.err = e_err;
        exp_rsp.push_back(r);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        acc = -1;
        for (int k = 0; k < 300; k++) begin
            if (cmd_ready) begin
                acc = cyc;
                tick();
                break;
            end
            tick();
        end
        cmd_valid = 1'b0;
        if (acc < 0) chk("cmd_accept_wait", 0, 1);
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 300 && exp_rsp.size() != 0; k++) tick();
        if (exp_rsp.size() != 0) chk("rsp_wait_expired", 0, 1);
        tick();
    endtask

    int acc, acc2, hs_cyc, n;

    initial begin
        axi_reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;
        repeat (3) tick();
        chk("reset_outputs",
            {cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, err_timeout,
             awvalid, wvalid, bready, arvalid, rready, awaddr[15:0], araddr[15:0]}, 0);
        axi_reset = 1'b0;
        chk("cmd_ready_in_reset_release", cmd_ready, 0);
        tick();
        chk("cmd_ready_after_reset", cmd_ready, 1);

        // 1: simple write, zero-wait slave, latency accept -> rsp_valid
        send_cmd(1, 32'h77a6_0004, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00, 0, 0, acc);
        n = 0;
        while (!rsp_valid && n < 50) begin tick(); n++; end
        chk("write_latency", cyc - acc, 4);
        wait_done();

        // 2: W before AW (slave error response), then AW before W
        aw_dly = 3; w_dly = 0; s_bresp = 2'b10;
        send_cmd(1, 32'h77a6_0020, 32'hA5A5_0001, 4'h5, 32'h0, 2'b10, 0, 0, acc);
        wait_done();
        aw_dly = 0; w_dly = 3; s_bresp = 2'b00;
        send_cmd(1, 32'h77a6_0024, 32'h5A5A_0002, 4'hC, 32'h0, 2'b00, 0, 0, acc);
        wait_done();
        w_dly = 0;

        // 3: read with delayed RVALID
        r_dly = 5; s_rdata = 32'h1234_5678; s_rresp = 2'b00;
        send_cmd(0, 32'h77a6_0010, 32'h0, 4'h0, 32'h1234_5678, 2'b00, 0, 0, acc);
        wait_done();
        r_dly = 0;

        // 5: unaligned read, response stalled, second command queued behind it
        s_rdata = 32'hCAFE_F00D; rsp_ready = 1'b0;
        send_cmd(0, 32'h77a6_0003, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b00, 0, 0, acc);
        hs_cyc = 0;
        fork
            send_cmd(1, 32'h77a6_0008, 32'h0102_0304, 4'h3, 32'h0, 2'b00, 0, 0, acc2);
            begin
                n = 0;
                while (!rsp_valid && n < 50) begin tick(); n++; end
                repeat (10) tick();
                hs_cyc = cyc;
                rsp_ready = 1'b1;
                tick();
            end
        join
        chk("second_cmd_after_rsp", acc2 > hs_cyc, 1);
        wait_done();

        // 4: read timeout, then error flag persists across a normal write
        r_never = 1'b1;
        send_cmd(0, 32'h77a6_0014, 32'h0, 4'h0, 32'h0, 2'b10, 1, 1, acc);
        n = 0;
        while (!rready && n < 50) begin tick(); n++; end
        n = 0;
        while (rready && n < 100) begin tick(); n++; end
        chk("rready_width", n, c_TO);
        wait_done();
        send_cmd(1, 32'h77a6_0030, 32'h0BAD_F00D, 4'hF, 32'h0, 2'b00, 0, 1, acc);
        wait_done();
        chk("err_timeout_sticky", err_timeout, 1);

        // 6: reset in the middle of a write request
        aw_dly = 20;
        send_cmd(1, 32'h77a6_0040, 32'h1111_2222, 4'hF, 32'h0, 2'b00, 0, 0, acc);
        n = 0;
        while (!awvalid && n < 20) begin tick(); n++; end
        axi_reset = 1'b1;
        exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_rsp.delete();
        tick();
        chk("mid_reset_outputs",
            {awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready, err_timeout}, 0);
        tick();
        axi_reset = 1'b0; aw_dly = 0; r_never = 1'b0;
        tick();
        send_cmd(1, 32'h77a6_0044, 32'h3333_4444, 4'h9, 32'h0, 2'b00, 0, 0, acc);
        wait_done();

        chk("queues_drained", exp_aw.size() + exp_w.size() + exp_ar.size() + exp_rsp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
